pri_normalizer: RTL and testbench

Parametrised, pipelined priority encoder and normalising shifter with valid/ready handshaking. Each transaction carries a WIDTH-bit word and a per-transaction search mode. The block finds the most-significant set bit (mode 0) or least-significant set bit (mode 1), reports its index and the zero count from the searched end, and returns the word shifted so that bit lands at the MSB (mode 0) or at bit 0 (mode 1). It sits in the floating-point add/sub datapaths, after the mantissa subtractor, where it feeds the exponent adjust.

---
 rtl/pri_normalizer.sv | 148 ++++++++++++++
 tb/tb_pri_normalizer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_normalizer.sv
// Purpose : leading/trailing-one priority encoder and normalising shifter.
// Latency : 2 cycles (S1 captures the word, S2 holds the encoded result).
// Backpressure: valid/ready per stage; in_ready follows out_ready combinationally, bubbles collapse.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input handshake; in_data word, in_mode 0=MSB-first 1=LSB-first
//   out_valid/out_ready     output handshake
//   out_idx, out_cnt        found-one index and zero count from the searched end
//   out_norm, out_zero      normalised word, all-zero flag; out_mode echoes in_mode
module pri_normalizer #(
   parameter int WIDTH = 56,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_cnt,
   output logic [WIDTH-1:0] out_norm,
   output logic             out_zero,
   output logic             out_mode
);

   // Tree depth and the power-of-two width the word is zero-padded to.
   localparam int LEVELS = $clog2(WIDTH);
   localparam int PW     = 1 << LEVELS;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(WIDTH);

   // ---------------------------------------------------------------
   // Stage registers and advance logic
   // ---------------------------------------------------------------
   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic             s1_mode;

   logic s2_adv;
   logic s1_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // ---------------------------------------------------------------
   // Encoder (combinational, between S1 and S2)
   // ---------------------------------------------------------------
   logic [WIDTH-1:0]  rev_word;
   logic [WIDTH-1:0]  search_word;
   logic [PW-1:0]     win;
   logic [PW-1:0]     upper;
   logic [LEVELS-1:0] tree_idx;
   logic              enc_zero;
   logic [CNT_W-1:0]  enc_idx;
   logic [CNT_W-1:0]  enc_cnt;
   logic [WIDTH-1:0]  enc_norm;

   // Trailing-one search reuses the leading-one tree on the reversed word.
   always_comb begin
      rev_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev_word[i] = s1_data[WIDTH-1-i];
      end
   end

   assign search_word = s1_mode ? rev_word : s1_data;

   // Binary OR-reduction tree: at each level, if the upper half of the
   // current window holds any one, that half is kept and the index bit
   // for this level is set; otherwise the lower half is kept.
   always_comb begin
      win      = PW'(search_word);
      upper    = '0;
      tree_idx = '0;
      for (int lvl = LEVELS - 1; lvl >= 0; lvl--) begin
         upper = win >> (1 << lvl);
         if (|upper) begin
            tree_idx[lvl] = 1'b1;
            win           = upper;
         end else begin
            win = win & ~({PW{1'b1}} << (1 << lvl));
         end
      end
   end

   assign enc_zero = ~|s1_data;

   // Tree index r is the leading-one position of search_word. For mode 0
   // that is idx directly; for mode 1 the real trailing-one index is
   // WIDTH-1-r. In both modes the zero count from the searched end is
   // WIDTH-1-r.
   always_comb begin
      enc_idx  = '0;
      enc_cnt  = CNT_ZERO;
      enc_norm = '0;
      if (!enc_zero) begin
         enc_cnt = CNT_MAX - CNT_W'(tree_idx);
         enc_idx = s1_mode ? enc_cnt : CNT_W'(tree_idx);
         enc_norm = s1_mode ? (s1_data >> enc_cnt) : (s1_data << enc_cnt);
      end
   end

   // ---------------------------------------------------------------
   // S1: input capture
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_mode <= in_mode;
         end
      end
   end

   // ---------------------------------------------------------------
   // S2: result registers drive the outputs directly
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_cnt   <= '0;
         out_norm  <= '0;
         out_zero  <= 1'b0;
         out_mode  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_idx  <= enc_idx;
            out_cnt  <= enc_cnt;
            out_norm <= enc_norm;
            out_zero <= enc_zero;
            out_mode <= s1_mode;
         end
      end
   end

endmodule

// File: tb/tb_pri_normalizer.sv
// Bench for pri_normalizer: scoreboard of expected results fed by the
// stimulus driver, drained by an independent output monitor.
module tb_pri_normalizer;

   localparam int W  = 56;
   localparam int CW = $clog2(W + 1);

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_idx;
   logic [CW-1:0] out_cnt;
   logic [W-1:0]  out_norm;
   logic          out_zero;
   logic          out_mode;

   pri_normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_cnt   (out_cnt),
      .out_norm  (out_norm),
      .out_zero  (out_zero),
      .out_mode  (out_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] idx;
      logic [CW-1:0] cnt;
      logic [W-1:0]  norm;
      logic          zero;
      logic          mode;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   rdy_mode = 0;   // 0: main block drives out_ready, 1: alternate, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: plain bit scan from the searched end.
   function automatic exp_t model(input logic [W-1:0] d, input logic m);
      exp_t e;
      int   pos;
      pos = -1;
      if (!m) begin
         for (int i = 0; i < W; i++) if (d[i]) pos = i;
      end else begin
         for (int i = W - 1; i >= 0; i--) if (d[i]) pos = i;
      end
      e.mode = m;
      e.acc  = 0;
      e.lat  = 0;
      if (pos < 0) begin
         e.zero = 1'b1;
         e.idx  = '0;
         e.cnt  = CW'(W);
         e.norm = '0;
      end else begin
         e.zero = 1'b0;
         e.idx  = CW'(pos);
         e.cnt  = m ? CW'(pos) : CW'(W - 1 - pos);
         e.norm = m ? (d >> e.cnt) : (d << e.cnt);
      end
      return e;
   endfunction

   // Drives one transaction starting at posedge+1; returns at posedge+1
   // after the transferring edge.
   task automatic send(input logic [W-1:0] d, input logic m, input bit lat);
      exp_t e;
      int   waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e     = model(d, m);
            e.acc = cyc;
            e.lat = lat;
            q.push_back(e);
            break;
         end
         waited++;
         if (waited > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", waited);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain_empty", q.size(), 0);
      repeat (2) @(negedge clk);
      chk("idle_after_drain", out_valid, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // out_ready patterns for backpressure phases.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) out_ready = ~out_ready;
         else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: occupancy vs in_ready, stall stability, scoreboard pops.
   initial begin
      logic          prev_stall;
      logic [127:0]  held;
      exp_t          e;
      prev_stall = 1'b0;
      held       = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n)
            chk("in_ready_vs_occupancy", in_ready, !(q.size() == 2 && !out_ready));
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("stall_hold", {out_valid, out_idx, out_cnt, out_norm, out_zero, out_mode}, held);
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: idx=%0d cnt=%0d with empty scoreboard, expected none",
                           out_idx, out_cnt);
               end else begin
                  e = q.pop_front();
                  chk("result", {out_idx, out_cnt, out_norm, out_zero, out_mode},
                      {e.idx, e.cnt, e.norm, e.zero, e.mode});
                  if (e.lat) chk("latency", cyc - e.acc, 2);
               end
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, out_idx, out_cnt, out_norm, out_zero, out_mode};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] one;
      logic [W-1:0] d;
      ones      = '1;
      one       = W'(1);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_idx",   out_idx,   '0);
      chk("rst_out_cnt",   out_cnt,   '0);
      chk("rst_out_norm",  out_norm,  '0);
      chk("rst_out_zero",  out_zero,  1'b0);
      chk("rst_out_mode",  out_mode,  1'b0);
      chk("rst_in_ready",  in_ready,  1'b1);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed boundary cases, unstalled output, latency checked
      out_ready = 1'b1;
      send(one << 55, 1'b0, 1'b1);
      send(one, 1'b0, 1'b1);
      send('0, 1'b0, 1'b1);
      send('0, 1'b1, 1'b1);
      send(W'(56'hA0), 1'b1, 1'b1);
      send(one << 55, 1'b1, 1'b1);
      send(ones, 1'b1, 1'b1);
      send(ones, 1'b0, 1'b1);
      drain();

      // Thermometer sweep with alternating out_ready
      rdy_mode = 1;
      for (int k = 0; k < W; k++) send(ones >> (k + 1), 1'b0, 1'b0);
      rdy_mode  = 0;
      out_ready = 1'b1;
      drain();

      // Reset with two transactions in flight
      out_ready = 1'b0;
      send(W'(56'h00F0_0000_1234), 1'b0, 1'b0);
      send(W'(56'h8000_0000_0001), 1'b1, 1'b0);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_out_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_rst_out_valid", out_valid, 1'b0);
      chk("async_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      send(W'(56'h100), 1'b0, 1'b1);
      drain();

      // Randomised traffic with random backpressure
      rdy_mode = 2;
      repeat (400) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         d = W'({$urandom, $urandom});
         d = d >> $urandom_range(0, W);
         if ($urandom_range(0, 3) == 0) d = d & (ones << $urandom_range(0, W - 1));
         send(d, 1'($urandom_range(0, 1)), 1'b0);
      end
      rdy_mode  = 0;
      out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
